// File: rtl/divisor.sv
// Sequential signed divider for the HI/LO datapath (MIPS DIV semantics).
// Restoring algorithm on operand magnitudes, one quotient bit per cycle, with a sign-fix state.
module divisor #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             divOrMult,
  input  logic [WIDTH-1:0] outA,
  input  logic [WIDTH-1:0] outB,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             ciclos_end,
  output logic             div_zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  // Operand context captured on an accepted start.
  typedef struct packed {
    logic [WIDTH-1:0] dvs;
    logic             sign_q;
    logic             sign_r;
  } op_t;

  state_t           state, state_nxt;
  op_t              op;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [CW-1:0]    cnt;

  logic             b_zero;
  logic             start_ok;
  logic             start_zero;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             q_bit;

  // Magnitudes are unsigned, so the most negative value maps onto itself correctly.
  always_comb begin
    mag_a      = outA[WIDTH-1] ? (~outA + 1'b1) : outA;
    mag_b      = outB[WIDTH-1] ? (~outB + 1'b1) : outB;
    b_zero     = (outB == '0);
    start_ok   = (state == IDLE) && divOrMult && !b_zero;
    start_zero = (state == IDLE) && divOrMult && b_zero;
  end

  // rem < dvs <= 2^(WIDTH-1) keeps diff small when non-negative, so its MSB is the borrow.
  always_comb begin
    rem_sh = {rem, quo[WIDTH-1]};
    diff   = rem_sh - {1'b0, op.dvs};
    q_bit  = ~diff[WIDTH];
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = RUN;
      RUN:     if (cnt == CW'(1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clock) begin
    if (!reset) begin
      op         <= '0;
      rem        <= '0;
      quo        <= '0;
      cnt        <= '0;
      hi         <= '0;
      lo         <= '0;
      ciclos_end <= 1'b0;
      div_zero   <= 1'b0;
    end else begin
      ciclos_end <= 1'b0;
      div_zero   <= start_zero;
      case (state)
        IDLE: begin
          if (start_ok) begin
            op.dvs    <= mag_b;
            op.sign_q <= outA[WIDTH-1] ^ outB[WIDTH-1];
            op.sign_r <= outA[WIDTH-1];
            rem       <= '0;
            quo       <= mag_a;
            cnt       <= CW'(WIDTH);
          end
        end
        RUN: begin
          rem <= q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], q_bit};
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          lo         <= op.sign_q ? (~quo + 1'b1) : quo;
          hi         <= op.sign_r ? (~rem + 1'b1) : rem;
          ciclos_end <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divisor.sv
// Self-checking bench for divisor: vector table through a timed scoreboard,
// plus divide-by-zero, ignored-start, mid-run reset and back-to-back sequences.
module tb_divisor;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         divOrMult;
  logic [W-1:0] outA, outB, hi, lo;
  logic         ciclos_end, div_zero, busy;

  divisor #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .divOrMult(divOrMult),
    .outA(outA), .outB(outB), .hi(hi), .lo(lo),
    .ciclos_end(ciclos_end), .div_zero(div_zero), .busy(busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    int           at;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
  } vec_t;
  vec_t vecs[14];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, edge_cnt);
    end
  endtask

  // Result monitor: every ciclos_end must match the oldest expected result, at its edge.
  always @(negedge clock) begin
    exp_t e;
    if (ciclos_end === 1'b1) begin
      chk("end_vs_divzero", {31'b0, div_zero}, '0);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ciclos_end: got 1 expected 0 (edge %0d)", edge_cnt);
      end else begin
        e = sb.pop_front();
        chk("lo", lo, e.lo);
        chk("hi", hi, e.hi);
        chk("latency_edge", edge_cnt, e.at);
      end
    end
  end

  // Start sampled at the next edge N; result visible at the negedge after edge N+W+1.
  task automatic start_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] elo, input logic [W-1:0] ehi);
    @(negedge clock);
    outA = a;
    outB = b;
    divOrMult = 1'b1;
    sb.push_back('{elo, ehi, edge_cnt + W + 2});
    @(negedge clock);
    divOrMult = 1'b0;
    chk("busy_after_start", {31'b0, busy}, 1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clock);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: got no ciclos_end, expected %0d pending results", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs = '{
      '{32'd7,          32'd2,          32'h00000003, 32'h00000001},
      '{32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD, 32'hFFFFFFFF},
      '{32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD, 32'h00000001},
      '{32'hFFFFFFF9,   32'hFFFFFFFE,   32'h00000003, 32'hFFFFFFFF},
      '{32'h80000000,   32'hFFFFFFFF,   32'h80000000, 32'h00000000},
      '{32'h7FFFFFFF,   32'd1,          32'h7FFFFFFF, 32'h00000000},
      '{32'd5,          32'd9,          32'h00000000, 32'h00000005},
      '{32'd100,        32'd7,          32'd14,       32'd2},
      '{32'd0,          32'd5,          32'd0,        32'd0},
      '{32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2, 32'hFFFFFFFE},
      '{32'h80000000,   32'd1,          32'h80000000, 32'h00000000},
      '{32'h80000000,   32'h80000000,   32'h00000001, 32'h00000000},
      '{32'hFFFFFFFF,   32'h80000000,   32'h00000000, 32'hFFFFFFFF},
      '{32'h12345678,   32'd1000,       32'h0004A90B, 32'h00000380}
    };

    reset = 1'b0;
    divOrMult = 1'b0;
    outA = '0;
    outB = '0;
    repeat (3) @(negedge clock);
    chk("rst_hi", hi, '0);
    chk("rst_lo", lo, '0);
    chk("rst_end", {31'b0, ciclos_end}, '0);
    chk("rst_divzero", {31'b0, div_zero}, '0);
    chk("rst_busy", {31'b0, busy}, '0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      start_div(vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi);
      wait_done();
    end

    // Divide by zero: rejected in IDLE, previous result untouched.
    start_div(32'd7, 32'd2, 32'd3, 32'd1);
    wait_done();
    @(negedge clock);
    outA = 32'd5;
    outB = 32'd0;
    divOrMult = 1'b1;
    @(negedge clock);
    divOrMult = 1'b0;
    chk("dz_pulse", {31'b0, div_zero}, 1);
    chk("dz_busy", {31'b0, busy}, 0);
    chk("dz_end", {31'b0, ciclos_end}, 0);
    chk("dz_lo_hold", lo, 32'd3);
    chk("dz_hi_hold", hi, 32'd1);
    @(negedge clock);
    chk("dz_one_cycle", {31'b0, div_zero}, 0);
    chk("dz_busy2", {31'b0, busy}, 0);

    // Start while busy is ignored and operands are not resampled.
    start_div(32'd100, 32'd7, 32'd14, 32'd2);
    repeat (8) @(negedge clock);
    outA = 32'd1;
    outB = 32'd1;
    divOrMult = 1'b1;
    @(negedge clock);
    divOrMult = 1'b0;
    wait_done();
    repeat (5) @(negedge clock);

    // Reset mid-run aborts the division and clears the results.
    @(negedge clock);
    outA = 32'd100;
    outB = 32'd7;
    divOrMult = 1'b1;
    @(negedge clock);
    divOrMult = 1'b0;
    chk("abort_busy_run", {31'b0, busy}, 1);
    repeat (13) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    chk("abort_hi", hi, '0);
    chk("abort_lo", lo, '0);
    chk("abort_busy", {31'b0, busy}, 0);
    repeat (40) @(negedge clock);
    start_div(32'd9, 32'd3, 32'd3, 32'd0);
    wait_done();

    // Strobe held high: a new division every W+2 edges.
    @(negedge clock);
    outA = 32'd20;
    outB = 32'd6;
    divOrMult = 1'b1;
    sb.push_back('{32'd3, 32'd2, edge_cnt + W + 2});
    sb.push_back('{32'd3, 32'd2, edge_cnt + 2 * W + 4});
    repeat (40) @(negedge clock);
    divOrMult = 1'b0;
    wait_done();
    repeat (40) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
